tlb_asid_plru: RTL and testbench
================================

# tlb_asid_plru

Set-associative translation lookaside buffer with a configurable way count and tree pseudo-LRU replacement. It adds an ASID-selective flush, performed by a set-sweep state machine, to the existing lookup, update, invalidate and invalidate-all commands. It is instantiated once in the instruction fetch path and once in the data cache tag stage, and replaces the fixed round-robin TLB in both.

## Interface
- NUM_ENTRIES, 64, total entries; must be a multiple of NUM_WAYS; NUM_ENTRIES / NUM_WAYS must be a power of two.
- NUM_WAYS, 4, associativity; power of two, minimum 2.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- lookup_en / update_en / invalidate_en / invalidate_all_en / invalidate_asid_en  in  1 each  commands; at most one asserted per cycle.
- request_vpage_idx  in  page_index_t  virtual page.
- request_asid  in  `ASID_WIDTH  address space ID; for invalidate_asid_en this is the ASID to flush.
- update_ppage_idx  in  page_index_t  physical page to install.
- update_present, update_exe_writable, update_supervisor, update_global  in  1 each  attributes to install.
- lookup_ppage_idx  out  page_index_t  translated page.
- lookup_hit, lookup_present, lookup_exe_writable, lookup_supervisor  out  1 each  lookup response.
- flush_busy  out  1  ASID sweep in progress.

## Operation
- **Entry contents.** Each entry stores vpage, asid, ppage, present, exe_writable, supervisor and global in a per-way sram_1r1w (READ_DURING_WRITE "NEW_DATA"). Valid bits live in flops.
- **Set index.** request_vpage_idx[SET_INDEX_WIDTH-1:0].
- **Hit condition.** A way hits when it is valid, its vpage matches, and either its asid matches or its global bit is set. lookup_hit is the OR of the way hits. The data outputs are an OR-mux of the hitting ways and are 0 on a miss.
- **Update.** On a hit, the hitting way is overwritten. On a miss, the PLRU victim way is written. The written way is marked valid.
- **Invalidate.** On a hit, the hitting way's valid bit is cleared. On a miss, nothing changes and the PLRU state is left alone.
- **Invalidate-all.** Clears every valid bit in one cycle. The PLRU state is untouched.
- **PLRU.** Each set holds NUM_WAYS-1 tree bits in flops, all 0 at reset.
  - A lookup hit or an update touches the used way: the bits along its path are set to point away from it.
  - The victim is found by following the bits from the root.
- **ASID flush FSM** (states IDLE, SWEEP, DRAIN):
  - IDLE → SWEEP on invalidate_asid_en. The ASID is latched into flush_asid and the sweep counter is set to 0.
  - In SWEEP, the FSM reads set `counter` from all ways and increments the counter. For the set read on the previous cycle, it clears the valid bit of every way whose asid equals flush_asid and whose global bit is 0.
  - SWEEP → DRAIN when the counter wraps from NUM_SETS-1 to 0. DRAIN clears the last set, then returns to IDLE.
  - flush_busy is high in SWEEP and DRAIN.
  - Requesters must not issue any command while flush_busy is high. An assertion fires if they do.
- **Hazard rules.**
  - An update or invalidate in stage 2 to the same set that stage 1 is reading bypasses the valid bit, as in the existing TLB.
  - Sweep clears use the same path.
  - Because of the no-command rule, no other hazard can occur during a sweep.
- **Duplicate entries.** An assertion checks that way hits are $onehot0 whenever stage 2 holds a lookup, update or invalidate.

## Timing
- **Lookup latency.** lookup_en in cycle N gives the response in N+1. The response is valid only in N+1; it is not held.
- **Update/invalidate.** Issued in N: tag compare in N+1, SRAM, valid bit and PLRU written at the end of N+1. A lookup issued in N+1 to the same entry sees the new data.
- **Invalidate-all.** Takes effect at the end of the issuing cycle. A lookup issued in the following cycle misses.
- **ASID flush length.**
  - invalidate_asid_en issued in cycle N: flush_busy is high in N+1 through N+NUM_SETS+1 and low in N+NUM_SETS+2.
  - Total flush occupancy is NUM_SETS+1 cycles.
- **Reset.**
  - All outputs 0, flush_busy 0, FSM in IDLE.
  - All valid bits and PLRU bits 0.
  - Reset asserted mid-sweep aborts the sweep immediately. Every entry is then invalid, because reset clears the valid bits.
- **Counter.** The sweep counter is SET_INDEX_WIDTH bits wide. The wrap from NUM_SETS-1 to 0 is the terminal condition; there is no extra compare bit.

## Structure
- page_index_t, PAGE_NUM_BITS and ASID_WIDTH come from defines.sv.
- The tlb_flush_state_t enum (IDLE, SWEEP, DRAIN) goes in defines.sv.
- One sub-module, tlb_plru_tree: parameterised by NUM_WAYS, combinational. Its inputs are the current bits, the touch enable and the touched way. Its outputs are the next bits and the victim one-hot. The per-set flop array stays in tlb_asid_plru.
- SRAM: one sram_1r1w per way, as in the existing TLB.

## Test plan
- **Install and hit.** update vpage 0x12345, asid 3, ppage 0x00abc, present, writable; then a lookup with asid 3. Required: in the cycle after the lookup, hit=1, ppage=0x00abc, present=1, exe_writable=1. A lookup with asid 4 misses.
- **Global entry.** update with global=1, asid 2; then a lookup with asid 7. Required: hit. After invalidate_asid 2 completes, the lookup still hits.
- **PLRU.** Fill all 4 ways of set 0 in order with vpages A, B, C, D (every vpage maps to set 0), then look up A. A fifth update with vpage E must evict B: a lookup of B misses, and lookups of A, C, D and E hit.
- **ASID sweep with default parameters.**
  - Setup: 5 entries with asid 5 spread across sets 0, 7, 15, and 3 entries with asid 6.
  - Issue invalidate_asid 5 in cycle N.
  - Required: flush_busy is high in N+1..N+17 and low in N+18. After that, all asid-5 lookups miss and all asid-6 lookups hit.
- **Update bypass.** update vpage V in cycle N, lookup V in N+1. Required: hit in N+2 with the new ppage. invalidate V in N+3, lookup V in N+4. Required: miss in N+5.
- **Reset mid-sweep.** Assert reset 4 cycles into a sweep. Required: flush_busy=0 during reset, and every lookup misses after release.

Source files
------------

// File: rtl/tlb_asid_plru_pkg.sv
// Shared types for the ASID-aware TLB: page/ASID widths, entry payload and flush FSM states.
package tlb_asid_plru_pkg;

    localparam int unsigned PAGE_NUM_BITS = 20;
    localparam int unsigned ASID_WIDTH    = 8;

    typedef logic [PAGE_NUM_BITS-1:0] page_index_t;
    typedef logic [ASID_WIDTH-1:0]    asid_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } tlb_flush_state_t;

    typedef struct packed {
        page_index_t vpage;
        asid_t       asid;
        page_index_t ppage;
        logic        present;
        logic        exe_writable;
        logic        supervisor;
        logic        is_global;
    } tlb_entry_t;

    localparam int unsigned ENTRY_BITS = $bits(tlb_entry_t);

endpackage

// File: rtl/sram_1r1w.sv
// One-read one-write synchronous RAM; a read to the address being written returns the new data.
module sram_1r1w #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tlb_plru_tree.sv
// Tree pseudo-LRU for one set: victim lookup from the root and path update on a touch.
module tlb_plru_tree #(
    parameter  int unsigned NUM_WAYS = 4,
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS),
    localparam int unsigned NODE_W   = (NUM_WAYS > 2) ? $clog2(NUM_WAYS - 1) : 1
) (
    input  logic [NUM_WAYS-2:0] bits_i,
    input  logic                touch_en_i,
    input  logic [WAY_W-1:0]    touch_way_i,
    output logic [NUM_WAYS-2:0] bits_o,
    output logic [NUM_WAYS-1:0] victim_o
);

    // Node n has children 2n+1 (bit 0, left) and 2n+2 (bit 1, right); a bit points at the victim side.
    always_comb begin
        int unsigned      node;
        logic             dir;
        logic [WAY_W-1:0] vidx;
        logic [WAY_W-1:0] tway;

        bits_o   = bits_i;
        victim_o = '0;
        vidx     = '0;
        node     = 0;
        for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
            dir  = bits_i[NODE_W'(node)];
            vidx = (vidx << 1) | WAY_W'(dir);
            node = 2 * node + 1 + 32'(dir);
        end
        victim_o[vidx] = 1'b1;

        tway = touch_way_i;
        node = 0;
        if (touch_en_i) begin
            for (int unsigned lvl = 0; lvl < WAY_W; lvl++) begin
                dir                      = tway[WAY_W-1];
                bits_o[NODE_W'(node)]    = ~dir;
                node                     = 2 * node + 1 + 32'(dir);
                tway                     = tway << 1;
            end
        end
    end

endmodule

// File: rtl/tlb_asid_plru.sv
// Set-associative TLB with tree PLRU replacement and an ASID-selective flush that sweeps every set.
module tlb_asid_plru
    import tlb_asid_plru_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 64,
    parameter int unsigned NUM_WAYS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_en,
    input  logic                  update_en,
    input  logic                  invalidate_en,
    input  logic                  invalidate_all_en,
    input  logic                  invalidate_asid_en,
    input  page_index_t           request_vpage_idx,
    input  logic [ASID_WIDTH-1:0] request_asid,
    input  page_index_t           update_ppage_idx,
    input  logic                  update_present,
    input  logic                  update_exe_writable,
    input  logic                  update_supervisor,
    input  logic                  update_global,
    output page_index_t           lookup_ppage_idx,
    output logic                  lookup_hit,
    output logic                  lookup_present,
    output logic                  lookup_exe_writable,
    output logic                  lookup_supervisor,
    output logic                  flush_busy
);

    localparam int unsigned NUM_SETS = NUM_ENTRIES / NUM_WAYS;
    localparam int unsigned SET_W    = $clog2(NUM_SETS);
    localparam int unsigned WAY_W    = $clog2(NUM_WAYS);

    tlb_flush_state_t                    state_q, state_d;
    logic [SET_W-1:0]                    counter_q, counter_d;
    asid_t                               flush_asid_q, flush_asid_d;
    logic                                s2_lookup_q, s2_lookup_d;
    logic                                s2_update_q, s2_update_d;
    logic                                s2_inval_q, s2_inval_d;
    logic                                s2_sweep_q, s2_sweep_d;
    logic [SET_W-1:0]                    s2_set_q, s2_set_d;
    tlb_entry_t                          s2_entry_q, s2_entry_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]   valid_q, valid_d;
    logic [NUM_SETS-1:0][NUM_WAYS-2:0]   plru_q, plru_d;

    logic [SET_W-1:0]    rd_set_c;
    tlb_entry_t          rd_entry [NUM_WAYS];
    logic [NUM_WAYS-1:0] set_valid_c, match_c, kill_c, victim_c, way_sel_c, way_we_c;
    logic [NUM_WAYS-2:0] plru_next_c;
    logic                any_hit_c, touch_c;
    logic [WAY_W-1:0]    touch_way_c;

    // Stage 1 reads the requested set, or the sweep counter while sweeping.
    assign rd_set_c = (state_q == SWEEP) ? counter_q : request_vpage_idx[SET_W-1:0];

    assign set_valid_c = valid_q[s2_set_q];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        logic [ENTRY_BITS-1:0] rdata;

        sram_1r1w #(
            .DEPTH (NUM_SETS),
            .WIDTH (ENTRY_BITS)
        ) u_sram (
            .clk   (clk),
            .we    (way_we_c[w]),
            .waddr (s2_set_q),
            .wdata (s2_entry_q),
            .raddr (rd_set_c),
            .rdata (rdata)
        );

        assign rd_entry[w] = tlb_entry_t'(rdata);
        assign match_c[w]  = set_valid_c[w] && (rd_entry[w].vpage == s2_entry_q.vpage)
                             && ((rd_entry[w].asid == s2_entry_q.asid) || rd_entry[w].is_global);
        assign kill_c[w]   = s2_sweep_q && set_valid_c[w]
                             && (rd_entry[w].asid == flush_asid_q) && !rd_entry[w].is_global;
    end

    assign any_hit_c = |match_c;
    assign way_sel_c = any_hit_c ? match_c : victim_c;
    assign way_we_c  = {NUM_WAYS{s2_update_q}} & way_sel_c;
    assign touch_c   = s2_update_q || (s2_lookup_q && any_hit_c);

    always_comb begin
        touch_way_c = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (way_sel_c[w]) begin
                touch_way_c = WAY_W'(w);
            end
        end
    end

    tlb_plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .bits_i      (plru_q[s2_set_q]),
        .touch_en_i  (touch_c),
        .touch_way_i (touch_way_c),
        .bits_o      (plru_next_c),
        .victim_o    (victim_c)
    );

    // Lookup response: OR-mux of hitting ways, all zero on a miss or a non-lookup.
    always_comb begin
        lookup_hit          = s2_lookup_q && any_hit_c;
        lookup_ppage_idx    = '0;
        lookup_present      = 1'b0;
        lookup_exe_writable = 1'b0;
        lookup_supervisor   = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (s2_lookup_q && match_c[w]) begin
                lookup_ppage_idx    = lookup_ppage_idx | rd_entry[w].ppage;
                lookup_present      = lookup_present | rd_entry[w].present;
                lookup_exe_writable = lookup_exe_writable | rd_entry[w].exe_writable;
                lookup_supervisor   = lookup_supervisor | rd_entry[w].supervisor;
            end
        end
    end

    assign flush_busy = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        flush_asid_d = flush_asid_q;
        case (state_q)
            IDLE: begin
                if (invalidate_asid_en) begin
                    state_d      = SWEEP;
                    counter_d    = '0;
                    flush_asid_d = request_asid;
                end
            end
            SWEEP: begin
                counter_d = counter_q + SET_W'(1);
                if (counter_q == SET_W'(NUM_SETS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s2_lookup_d = lookup_en;
        s2_update_d = update_en;
        s2_inval_d  = invalidate_en;
        s2_sweep_d  = (state_q == SWEEP);
        s2_set_d    = rd_set_c;
        s2_entry_d  = '{vpage: request_vpage_idx, asid: request_asid, ppage: update_ppage_idx,
                        present: update_present, exe_writable: update_exe_writable,
                        supervisor: update_supervisor, is_global: update_global};

        valid_d = valid_q;
        plru_d  = plru_q;
        plru_d[s2_set_q] = plru_next_c;
        if (s2_update_q) begin
            valid_d[s2_set_q] = valid_d[s2_set_q] | way_we_c;
        end
        if (s2_inval_q) begin
            valid_d[s2_set_q] = valid_d[s2_set_q] & ~match_c;
        end
        if (s2_sweep_q) begin
            valid_d[s2_set_q] = valid_d[s2_set_q] & ~kill_c;
        end
        if (invalidate_all_en) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            flush_asid_q <= '0;
            s2_lookup_q  <= 1'b0;
            s2_update_q  <= 1'b0;
            s2_inval_q   <= 1'b0;
            s2_sweep_q   <= 1'b0;
            s2_set_q     <= '0;
            s2_entry_q   <= '0;
            valid_q      <= '0;
            plru_q       <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            flush_asid_q <= flush_asid_d;
            s2_lookup_q  <= s2_lookup_d;
            s2_update_q  <= s2_update_d;
            s2_inval_q   <= s2_inval_d;
            s2_sweep_q   <= s2_sweep_d;
            s2_set_q     <= s2_set_d;
            s2_entry_q   <= s2_entry_d;
            valid_q      <= valid_d;
            plru_q       <= plru_d;
        end
    end

    a_no_cmd_while_busy: assert property (@(posedge clk) disable iff (reset)
        flush_busy |-> !(lookup_en || update_en || invalidate_en || invalidate_all_en || invalidate_asid_en));

    a_one_cmd: assert property (@(posedge clk) disable iff (reset)
        $onehot0({lookup_en, update_en, invalidate_en, invalidate_all_en, invalidate_asid_en}));

    a_no_duplicates: assert property (@(posedge clk) disable iff (reset)
        (s2_lookup_q || s2_update_q || s2_inval_q) |-> $onehot0(match_c));

endmodule

// File: tb/tb_tlb_asid_plru.sv
// Directed bench for tlb_asid_plru: install/hit, global entries, PLRU victim order, ASID sweep, bypass, reset.
module tb_tlb_asid_plru;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_en, update_en, invalidate_en, invalidate_all_en, invalidate_asid_en;
    logic [19:0] request_vpage_idx;
    logic [7:0]  request_asid;
    logic [19:0] update_ppage_idx;
    logic        update_present, update_exe_writable, update_supervisor, update_global;
    logic [19:0] lookup_ppage_idx;
    logic        lookup_hit, lookup_present, lookup_exe_writable, lookup_supervisor;
    logic        flush_busy;

    int vectors     = 0;
    int miscompares = 0;

    tlb_asid_plru dut (
        .clk                 (clk),
        .reset               (reset),
        .lookup_en           (lookup_en),
        .update_en           (update_en),
        .invalidate_en       (invalidate_en),
        .invalidate_all_en   (invalidate_all_en),
        .invalidate_asid_en  (invalidate_asid_en),
        .request_vpage_idx   (request_vpage_idx),
        .request_asid        (request_asid),
        .update_ppage_idx    (update_ppage_idx),
        .update_present      (update_present),
        .update_exe_writable (update_exe_writable),
        .update_supervisor   (update_supervisor),
        .update_global       (update_global),
        .lookup_ppage_idx    (lookup_ppage_idx),
        .lookup_hit          (lookup_hit),
        .lookup_present      (lookup_present),
        .lookup_exe_writable (lookup_exe_writable),
        .lookup_supervisor   (lookup_supervisor),
        .flush_busy          (flush_busy)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [19:0] vp, input logic [7:0] asid, input logic [19:0] pp,
                             input logic pres, input logic wr, input logic sup, input logic glob);
        request_vpage_idx   = vp;
        request_asid        = asid;
        update_ppage_idx    = pp;
        update_present      = pres;
        update_exe_writable = wr;
        update_supervisor   = sup;
        update_global       = glob;
        update_en           = 1'b1;
        cycle();
        update_en           = 1'b0;
    endtask

    // Returns {hit, ppage, present, exe_writable, supervisor} sampled in the response cycle.
    task automatic do_lookup(input logic [19:0] vp, input logic [7:0] asid, output logic [23:0] resp);
        request_vpage_idx = vp;
        request_asid      = asid;
        lookup_en         = 1'b1;
        cycle();
        resp      = {lookup_hit, lookup_ppage_idx, lookup_present, lookup_exe_writable, lookup_supervisor};
        lookup_en = 1'b0;
    endtask

    task automatic do_invalidate(input logic [19:0] vp, input logic [7:0] asid);
        request_vpage_idx = vp;
        request_asid      = asid;
        invalidate_en     = 1'b1;
        cycle();
        invalidate_en     = 1'b0;
    endtask

    task automatic issue_flush(input logic [7:0] asid);
        request_asid       = asid;
        invalidate_asid_en = 1'b1;
        cycle();
        invalidate_asid_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        vectors++;
        if ({lookup_hit, lookup_ppage_idx, lookup_present, lookup_exe_writable, lookup_supervisor, flush_busy} !== 25'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got hit=%b ppage=%h busy=%b, want all 0", lookup_hit, lookup_ppage_idx, flush_busy);
        end
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_install_hit();
        logic [23:0] r;
        do_update(20'h12345, 8'd3, 20'h00abc, 1'b1, 1'b1, 1'b0, 1'b0);
        do_lookup(20'h12345, 8'd3, r);
        vectors++;
        if (r !== {1'b1, 20'h00abc, 3'b110}) begin
            miscompares++;
            $display("FAIL install_hit: got %h, want %h", r, {1'b1, 20'h00abc, 3'b110});
        end
        do_lookup(20'h12345, 8'd4, r);
        vectors++;
        if (r !== 24'h0) begin
            miscompares++;
            $display("FAIL install_other_asid: got %h, want 000000", r);
        end
    endtask

    task automatic test_global();
        logic [23:0] r;
        do_update(20'h00021, 8'd2, 20'h00777, 1'b1, 1'b0, 1'b1, 1'b1);
        do_lookup(20'h00021, 8'd7, r);
        vectors++;
        if (r !== {1'b1, 20'h00777, 3'b101}) begin
            miscompares++;
            $display("FAIL global_hit: got %h, want %h", r, {1'b1, 20'h00777, 3'b101});
        end
        issue_flush(8'd2);
        repeat (17) cycle();
        vectors++;
        if (flush_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL global_flush_done: busy=%b, want 0", flush_busy);
        end
        do_lookup(20'h00021, 8'd7, r);
        vectors++;
        if (r !== {1'b1, 20'h00777, 3'b101}) begin
            miscompares++;
            $display("FAIL global_after_flush: got %h, want %h", r, {1'b1, 20'h00777, 3'b101});
        end
        do_lookup(20'h12345, 8'd3, r);
        vectors++;
        if (r !== {1'b1, 20'h00abc, 3'b110}) begin
            miscompares++;
            $display("FAIL other_asid_after_flush: got %h, want %h", r, {1'b1, 20'h00abc, 3'b110});
        end
    endtask

    task automatic test_plru();
        logic [23:0] r;
        logic [19:0] vp [5];
        logic [4:0]  exp_hit;
        vp[0] = 20'h00100; vp[1] = 20'h00200; vp[2] = 20'h00300; vp[3] = 20'h00400; vp[4] = 20'h00500;
        for (int i = 0; i < 4; i++) do_update(vp[i], 8'd1, vp[i] ^ 20'hf0000, 1'b1, 1'b0, 1'b0, 1'b0);
        do_lookup(vp[0], 8'd1, r);
        vectors++;
        if (r !== {1'b1, vp[0] ^ 20'hf0000, 3'b100}) begin
            miscompares++;
            $display("FAIL plru_touch_A: got %h, want %h", r, {1'b1, vp[0] ^ 20'hf0000, 3'b100});
        end
        do_update(vp[4], 8'd1, vp[4] ^ 20'hf0000, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_hit = 5'b11101;
        for (int i = 0; i < 5; i++) begin
            do_lookup(vp[i], 8'd1, r);
            vectors++;
            if (r !== (exp_hit[i] ? {1'b1, vp[i] ^ 20'hf0000, 3'b100} : 24'h0)) begin
                miscompares++;
                $display("FAIL plru_way%0d: got %h, want hit=%b", i, r, exp_hit[i]);
            end
        end
    endtask

    task automatic test_invalidate_all();
        logic [23:0] r;
        invalidate_all_en = 1'b1;
        cycle();
        invalidate_all_en = 1'b0;
        do_lookup(20'h00100, 8'd1, r);
        vectors++;
        if (r !== 24'h0) begin
            miscompares++;
            $display("FAIL inval_all_A: got %h, want 000000", r);
        end
        do_lookup(20'h00021, 8'd7, r);
        vectors++;
        if (r !== 24'h0) begin
            miscompares++;
            $display("FAIL inval_all_global: got %h, want 000000", r);
        end
    endtask

    task automatic test_asid_sweep();
        logic [23:0] r;
        logic [19:0] vp [8];
        logic [7:0]  as [8];
        vp[0] = 20'h10000; vp[1] = 20'h20000; vp[2] = 20'h10007; vp[3] = 20'h20007; vp[4] = 20'h1000f;
        vp[5] = 20'h30000; vp[6] = 20'h30007; vp[7] = 20'h3000f;
        for (int i = 0; i < 8; i++) begin
            as[i] = (i < 5) ? 8'd5 : 8'd6;
            do_update(vp[i], as[i], vp[i] + 20'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        issue_flush(8'd5);
        for (int c = 1; c <= 17; c++) begin
            vectors++;
            if (flush_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL sweep_busy_N+%0d: busy=%b, want 1", c, flush_busy);
            end
            cycle();
        end
        vectors++;
        if (flush_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_busy_N+18: busy=%b, want 0", flush_busy);
        end
        for (int i = 0; i < 8; i++) begin
            do_lookup(vp[i], as[i], r);
            vectors++;
            if (r !== ((i < 5) ? 24'h0 : {1'b1, vp[i] + 20'd1, 3'b110})) begin
                miscompares++;
                $display("FAIL sweep_entry%0d: got %h, want hit=%b", i, r, i >= 5);
            end
        end
    endtask

    task automatic test_bypass();
        logic [23:0] r;
        do_update(20'h55555, 8'd3, 20'h11111, 1'b1, 1'b0, 1'b0, 1'b0);
        do_update(20'h55555, 8'd3, 20'h0beef, 1'b1, 1'b1, 1'b1, 1'b0);
        do_lookup(20'h55555, 8'd3, r);
        vectors++;
        if (r !== {1'b1, 20'h0beef, 3'b111}) begin
            miscompares++;
            $display("FAIL bypass_update: got %h, want %h", r, {1'b1, 20'h0beef, 3'b111});
        end
        cycle();
        do_invalidate(20'h55555, 8'd3);
        do_lookup(20'h55555, 8'd3, r);
        vectors++;
        if (r !== 24'h0) begin
            miscompares++;
            $display("FAIL bypass_invalidate: got %h, want 000000", r);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [23:0] r;
        logic [19:0] vp [3];
        vp[0] = 20'h0aaa1; vp[1] = 20'h0bbb2; vp[2] = 20'h0ccc3;
        for (int i = 0; i < 3; i++) do_update(vp[i], 8'd9, vp[i], 1'b1, 1'b0, 1'b0, 1'b0);
        issue_flush(8'd1);
        repeat (3) cycle();
        reset = 1'b1;
        #1;
        vectors++;
        if (flush_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_sweep_busy: busy=%b, want 0", flush_busy);
        end
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        for (int i = 0; i < 3; i++) begin
            do_lookup(vp[i], 8'd9, r);
            vectors++;
            if (r !== 24'h0) begin
                miscompares++;
                $display("FAIL reset_mid_sweep_entry%0d: got %h, want 000000", i, r);
            end
        end
        vectors++;
        if (flush_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_sweep_after: busy=%b, want 0", flush_busy);
        end
    endtask

    initial begin
        reset               = 1'b1;
        lookup_en           = 1'b0;
        update_en           = 1'b0;
        invalidate_en       = 1'b0;
        invalidate_all_en   = 1'b0;
        invalidate_asid_en  = 1'b0;
        request_vpage_idx   = '0;
        request_asid        = '0;
        update_ppage_idx    = '0;
        update_present      = 1'b0;
        update_exe_writable = 1'b0;
        update_supervisor   = 1'b0;
        update_global       = 1'b0;

        test_reset();
        test_install_hit();
        test_global();
        test_plru();
        test_invalidate_all();
        test_asid_sweep();
        test_bypass();
        test_reset_mid_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
